sprite_frame_streamer: RTL and testbench

Parametrised raster pixel source for the SPI LCD path. It scans a WIDTH x HEIGHT frame and places one integer-scaled sprite from an external synchronous ROM at a programmable window. Every other pixel is filled with a background colour. Pixels go to the display controller over a valid/ready handshake. It supports single-shot-on-change and continuous refresh modes, and defers sprite changes requested mid-frame to a frame boundary.

---
 rtl/sprite_frame_streamer.sv | 168 ++++++++++++++++
 tb/tb_sprite_frame_streamer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_frame_streamer.sv
// rtl/sprite_frame_streamer.sv - raster pixel source placing one scaled ROM sprite on a background
module sprite_frame_streamer #(
    parameter int                    WIDTH      = 240,
    parameter int                    HEIGHT     = 240,
    parameter int                    PIXEL_SIZE = 16,
    parameter int                    SCALE      = 5,
    parameter int                    SPRITE_W   = 48,
    parameter int                    SPRITE_H   = 48,
    parameter int                    ADDR_W     = 13,
    parameter int                    SEL_W      = 4,
    parameter logic [PIXEL_SIZE-1:0] BG_COLOR   = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SEL_W-1:0]           sprite_sel,
    input  logic [ADDR_W-1:0]          sprite_base,
    input  logic [$clog2(WIDTH)-1:0]   win_x,
    input  logic [$clog2(HEIGHT)-1:0]  win_y,
    input  logic                       continuous,
    output logic [ADDR_W-1:0]          rom_addr,
    input  logic [PIXEL_SIZE-1:0]      rom_rdata,
    output logic [PIXEL_SIZE-1:0]      pixel_data,
    output logic                       pixel_valid,
    input  logic                       pixel_ready,
    output logic                       frame_done
);

    localparam int          XW    = $clog2(WIDTH);
    localparam int          YW    = $clog2(HEIGHT);
    localparam int          SW    = $clog2(SCALE + 1);
    localparam logic [31:0] WIN_W = 32'(SPRITE_W * SCALE);
    localparam logic [31:0] WIN_H = 32'(SPRITE_H * SCALE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_STREAM,
        S_DONE
    } state_t;

    state_t              state;
    logic [XW-1:0]       x_q;
    logic [YW-1:0]       y_q;
    logic [SW-1:0]       sub_x_q;
    logic [SW-1:0]       sub_y_q;
    logic [ADDR_W-1:0]   tx_q;
    // row_addr_q holds base + ty*SPRITE_W so no multiplier is needed per pixel
    logic [ADDR_W-1:0]   row_addr_q;
    logic [XW-1:0]       win_x_q;
    logic [YW-1:0]       win_y_q;
    logic [SEL_W-1:0]    latched_sel;
    logic                pending;

    logic in_x;
    logic in_y;
    logic last_col;
    logic last_row;
    logic start;

    // Window membership of the current raster position, clipped by the frame edge naturally
    assign in_x     = (32'(x_q) >= 32'(win_x_q)) && (32'(x_q) < 32'(win_x_q) + WIN_W);
    assign in_y     = (32'(y_q) >= 32'(win_y_q)) && (32'(y_q) < 32'(win_y_q) + WIN_H);
    assign last_col = (x_q == XW'(WIDTH - 1));
    assign last_row = (y_q == YW'(HEIGHT - 1));
    assign start    = (state == S_IDLE) || ((state == S_DONE) && (continuous || pending));

    // Address is stable for the whole FETCH cycle so the synchronous ROM returns data during WAIT
    assign rom_addr = row_addr_q + tx_q;

    // Frame scan FSM: counters, texel tracking, handshake and deferred sprite changes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            sub_x_q     <= '0;
            sub_y_q     <= '0;
            tx_q        <= '0;
            row_addr_q  <= '0;
            win_x_q     <= '0;
            win_y_q     <= '0;
            latched_sel <= '0;
            pending     <= 1'b0;
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            if ((state != S_IDLE) && (sprite_sel != latched_sel)) begin
                pending <= 1'b1;
            end

            if (start) begin
                latched_sel <= sprite_sel;
                row_addr_q  <= sprite_base;
                win_x_q     <= win_x;
                win_y_q     <= win_y;
                pending     <= 1'b0;
                x_q         <= '0;
                y_q         <= '0;
                sub_x_q     <= '0;
                sub_y_q     <= '0;
                tx_q        <= '0;
                frame_done  <= 1'b0;
                state       <= S_FETCH;
            end else begin
                case (state)
                    S_FETCH: begin
                        if (in_x && in_y) begin
                            state <= S_WAIT;
                        end else begin
                            pixel_data  <= BG_COLOR;
                            pixel_valid <= 1'b1;
                            state       <= S_STREAM;
                        end
                    end
                    S_WAIT: begin
                        pixel_data  <= rom_rdata;
                        pixel_valid <= 1'b1;
                        state       <= S_STREAM;
                    end
                    S_STREAM: begin
                        if (pixel_ready) begin
                            pixel_valid <= 1'b0;
                            if (last_col) begin
                                x_q     <= '0;
                                sub_x_q <= '0;
                                tx_q    <= '0;
                                y_q     <= y_q + 1'b1;
                                if (in_y) begin
                                    if (sub_y_q == SW'(SCALE - 1)) begin
                                        sub_y_q    <= '0;
                                        row_addr_q <= row_addr_q + ADDR_W'(SPRITE_W);
                                    end else begin
                                        sub_y_q <= sub_y_q + 1'b1;
                                    end
                                end
                            end else begin
                                x_q <= x_q + 1'b1;
                                if (in_x) begin
                                    if (sub_x_q == SW'(SCALE - 1)) begin
                                        sub_x_q <= '0;
                                        tx_q    <= tx_q + 1'b1;
                                    end else begin
                                        sub_x_q <= sub_x_q + 1'b1;
                                    end
                                end
                            end
                            if (last_col && last_row) begin
                                frame_done <= 1'b1;
                                state      <= S_DONE;
                            end else begin
                                state <= S_FETCH;
                            end
                        end
                    end
                    S_DONE: begin
                        frame_done <= 1'b1;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sprite_frame_streamer.sv
// tb/tb_sprite_frame_streamer.sv - directed table-driven bench for sprite_frame_streamer
module tb_sprite_frame_streamer;

    localparam int          WIDTH  = 8;
    localparam int          HEIGHT = 4;
    localparam int          ADDR_W = 13;
    localparam logic [15:0] BG     = 16'h001F;
    localparam logic [15:0] PA     = 16'hA0A0;
    localparam logic [15:0] PB     = 16'hB0B0;
    localparam logic [15:0] PC     = 16'hC0C0;
    localparam logic [15:0] PD     = 16'hD0D0;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        sprite_sel;
    logic [ADDR_W-1:0] sprite_base;
    logic [2:0]        win_x;
    logic [1:0]        win_y;
    logic              continuous;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_rdata;
    logic [15:0]       pixel_data;
    logic              pixel_valid;
    logic              pixel_ready;
    logic              frame_done;

    logic [15:0] rom [0:(1<<ADDR_W)-1];
    logic [15:0] acc_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          x;
        int          y;
        logic [15:0] exp0;
        logic [15:0] exp3;
    } vec_t;
    vec_t vt [32];

    sprite_frame_streamer #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .PIXEL_SIZE(16), .SCALE(2),
        .SPRITE_W(2), .SPRITE_H(1), .ADDR_W(ADDR_W), .SEL_W(4), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .rst(rst), .sprite_sel(sprite_sel), .sprite_base(sprite_base),
        .win_x(win_x), .win_y(win_y), .continuous(continuous),
        .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_rdata <= rom[rom_addr];

    always @(negedge clk) begin
        if (rst && pixel_valid && pixel_ready) acc_q.push_back(pixel_data);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            tick();
            n++;
            if (frame_done) break;
        end
        check("frame_done_reached", {31'd0, frame_done}, 32'd1);
    endtask

    task automatic wait_count(input int target, input int budget);
        int n = 0;
        while (acc_q.size() < target && n < budget) begin
            tick();
            n++;
        end
        check("pixel_progress", acc_q.size() >= target, 32'd1);
    endtask

    task automatic check_frame(input int base, input bit s3, input string tag);
        for (int i = 0; i < 32; i++) begin
            logic [15:0] exp;
            exp = s3 ? vt[i].exp3 : vt[i].exp0;
            if (base + i < acc_q.size())
                check($sformatf("%s_px_x%0d_y%0d", tag, vt[i].x, vt[i].y), {16'd0, acc_q[base+i]}, {16'd0, exp});
            else
                check($sformatf("%s_missing_px%0d", tag, i), 32'd0, 32'd1);
        end
    endtask

    initial begin
        int          n;
        int          vcnt;
        int          lowcnt;
        logic [15:0] held;

        for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = 16'(i) ^ 16'h5A00;
        rom[100] = PA;
        rom[101] = PB;
        rom[200] = PC;
        rom[201] = PD;

        // Expected frame: window spans columns 2..5 and rows 1..2 (one texel row scaled by 2)
        for (int i = 0; i < 32; i++) begin
            vt[i].x    = i % WIDTH;
            vt[i].y    = i / WIDTH;
            vt[i].exp0 = BG;
            vt[i].exp3 = BG;
        end
        vt[10].exp0 = PA; vt[11].exp0 = PA; vt[12].exp0 = PB; vt[13].exp0 = PB;
        vt[18].exp0 = PA; vt[19].exp0 = PA; vt[20].exp0 = PB; vt[21].exp0 = PB;
        vt[10].exp3 = PC; vt[11].exp3 = PC; vt[12].exp3 = PD; vt[13].exp3 = PD;
        vt[18].exp3 = PC; vt[19].exp3 = PC; vt[20].exp3 = PD; vt[21].exp3 = PD;

        rst         = 1'b0;
        sprite_sel  = 4'd0;
        sprite_base = 13'd100;
        win_x       = 3'd2;
        win_y       = 2'd1;
        continuous  = 1'b0;
        pixel_ready = 1'b1;
        tick();
        tick();

        check("reset_valid", {31'd0, pixel_valid}, 32'd0);
        check("reset_data", {16'd0, pixel_data}, 32'd0);
        check("reset_rom_addr", {19'd0, rom_addr}, 32'd0);
        check("reset_frame_done", {31'd0, frame_done}, 32'd0);

        // First frame: 1 start cycle + 8 inside pixels * 3 + 24 outside pixels * 2
        rst = 1'b1;
        acc_q.delete();
        wait_done(500, n);
        check("frame_cycles", n, 32'd73);
        check("frame_pixel_count", acc_q.size(), 32'd32);
        check_frame(0, 1'b0, "f1");

        // Single-shot mode with unchanged selector stays idle in DONE
        vcnt = 0;
        lowcnt = 0;
        repeat (100) begin
            tick();
            if (pixel_valid) vcnt++;
            if (!frame_done) lowcnt++;
        end
        check("idle_valid_cycles", vcnt, 32'd0);
        check("idle_done_low_cycles", lowcnt, 32'd0);
        check("idle_pixel_count", acc_q.size(), 32'd32);

        // Reset in the middle of a frame
        rst = 1'b0;
        tick();
        rst = 1'b1;
        acc_q.delete();
        wait_count(10, 300);
        rst = 1'b0;
        #1;
        check("midreset_valid", {31'd0, pixel_valid}, 32'd0);
        check("midreset_frame_done", {31'd0, frame_done}, 32'd0);
        check("midreset_data", {16'd0, pixel_data}, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        acc_q.delete();
        wait_done(500, n);
        check("restart_pixel_count", acc_q.size(), 32'd32);
        check_frame(0, 1'b0, "frst");

        // Selector change mid-frame is deferred to the next frame boundary
        rst = 1'b0;
        tick();
        rst = 1'b1;
        acc_q.delete();
        wait_count(5, 300);
        sprite_sel  = 4'd3;
        sprite_base = 13'd200;
        wait_done(500, n);
        check("old_frame_count", acc_q.size(), 32'd32);
        check_frame(0, 1'b0, "fold");
        tick();
        check("pending_restart", {31'd0, frame_done}, 32'd0);
        wait_done(500, n);
        check("new_frame_count", acc_q.size(), 32'd64);
        check_frame(32, 1'b1, "fnew");
        repeat (5) tick();
        check("after_new_done", {31'd0, frame_done}, 32'd1);
        check("after_new_valid", {31'd0, pixel_valid}, 32'd0);

        // Continuous mode with a 7-cycle back-pressure stall on the first sprite pixel
        acc_q.delete();
        continuous = 1'b1;
        tick();
        check("cont_start", {31'd0, frame_done}, 32'd0);
        n = 0;
        while (!(acc_q.size() == 10 && pixel_valid) && n < 300) begin
            tick();
            n++;
        end
        check("stall_reached", {31'd0, pixel_valid}, 32'd1);
        pixel_ready = 1'b0;
        held = pixel_data;
        check("stall_pixel", {16'd0, held}, {16'd0, PC});
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("stall_valid_c%0d", i), {31'd0, pixel_valid}, 32'd1);
            check($sformatf("stall_data_c%0d", i), {16'd0, pixel_data}, {16'd0, held});
        end
        check("stall_no_transfer", acc_q.size(), 32'd10);
        pixel_ready = 1'b1;
        wait_done(500, n);
        check("cont1_count", acc_q.size(), 32'd32);
        check_frame(0, 1'b1, "c1");
        tick();
        check("cont_done_pulse", {31'd0, frame_done}, 32'd0);
        wait_done(500, n);
        continuous = 1'b0;
        check("cont2_count", acc_q.size(), 32'd64);
        check_frame(32, 1'b1, "c2");
        vcnt = 0;
        repeat (10) begin
            tick();
            if (pixel_valid) vcnt++;
        end
        check("cont_stop_valid", vcnt, 32'd0);
        check("cont_stop_count", acc_q.size(), 32'd64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
